// File: rtl/key_debounce_array.sv
// Per-channel two-flop synchronizer, debounce counter and press/release pulses for active-low keys.
// Define KEY_LONG_PRESS_EN to build the hold/auto-repeat logic (long_flag, repeat_flag); otherwise both stay 0.
module key_debounce_array #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_flag,
  output logic [NUM_KEYS-1:0] release_flag,
  output logic [NUM_KEYS-1:0] long_flag,
  output logic [NUM_KEYS-1:0] repeat_flag
);

  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] s;
  logic [DB_W-1:0]     db_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] accept;

  // A channel accepts its new level on the edge where the counter is already at its last value.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      accept[i] = (s[i] != key_state[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1        <= '1;
      s            <= '1;
      key_state    <= '1;
      press_flag   <= '0;
      release_flag <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= key_in;
      s     <= sync1;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        press_flag[i]   <= 1'b0;
        release_flag[i] <= 1'b0;
        if (s[i] == key_state[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          key_state[i]    <= s[i];
          db_cnt[i]       <= '0;
          press_flag[i]   <= ~s[i];
          release_flag[i] <= s[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES) + 1;
  localparam int unsigned       REP_W     = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    H_IDLE,
    H_LONG,
    H_REPEAT
  } hold_t;

  hold_t             phase    [NUM_KEYS];
  logic [HOLD_W-1:0] hold_cnt [NUM_KEYS];
  logic [REP_W-1:0]  rep_cnt  [NUM_KEYS];

  // Phase leaves H_IDLE only on an accepted press, so it is non-idle exactly while key_state is 0.
  // Release acceptance wins over the counters so no pulse can coincide with release_flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_flag   <= '0;
      repeat_flag <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        phase[i]    <= H_IDLE;
        hold_cnt[i] <= '0;
        rep_cnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        long_flag[i]   <= 1'b0;
        repeat_flag[i] <= 1'b0;
        if (accept[i] && s[i]) begin
          phase[i]    <= H_IDLE;
          hold_cnt[i] <= '0;
          rep_cnt[i]  <= '0;
        end else if (accept[i]) begin
          phase[i]    <= H_LONG;
          hold_cnt[i] <= '0;
          rep_cnt[i]  <= '0;
        end else begin
          case (phase[i])
            H_LONG: begin
              if (hold_cnt[i] == HOLD_LAST) begin
                long_flag[i] <= 1'b1;
                phase[i]     <= H_REPEAT;
                rep_cnt[i]   <= '0;
              end else begin
                hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
              end
            end
            H_REPEAT: begin
              if (rep_cnt[i] == REP_LAST) begin
                repeat_flag[i] <= 1'b1;
                rep_cnt[i]     <= '0;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
              end
            end
            default: begin
              hold_cnt[i] <= '0;
              rep_cnt[i]  <= '0;
            end
          endcase
        end
      end
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused  = (LONG_CYCLES > DEBOUNCE_CYCLES) && (REPEAT_CYCLES != 0);
  assign long_flag   = '0;
  assign repeat_flag = '0;
`endif

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed and randomized checks of key_debounce_array against a run-length / hold-age reference model.
module tb_key_debounce_array;

  localparam int NK = 2;
  localparam int DB = 4;
  localparam int LG = 16;
  localparam int RP = 8;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_state, press_flag, release_flag, long_flag, repeat_flag;

  always #5 clk = ~clk;

  key_debounce_array #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LG),
    .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .key_state(key_state),
    .press_flag(press_flag),
    .release_flag(release_flag),
    .long_flag(long_flag),
    .repeat_flag(repeat_flag)
  );

  int tests = 0;
  int fails = 0;
  int edge_no = 0;

  // Reference model: sampled level two edges late; accept after DB consecutive differing samples;
  // hold age counted in edges since the press pulse.
  logic [NK-1:0] m_sync1 = '1, m_sync2 = '1, m_state = '1;
  logic [NK-1:0] m_press = '0, m_rel = '0, m_long = '0, m_rep = '0;
  int m_run[NK];
  int m_age[NK];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_edge();
    logic [NK-1:0] s_old;
    logic [NK-1:0] st_old;
    bit rel_now;
    s_old  = m_sync2;
    st_old = m_state;
    edge_no++;
    m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
    if (rst) begin
      m_sync1 = '1; m_sync2 = '1; m_state = '1;
      for (int i = 0; i < NK; i++) begin m_run[i] = 0; m_age[i] = 0; end
    end else begin
      for (int i = 0; i < NK; i++) begin
        rel_now = 1'b0;
        if (s_old[i] != st_old[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_state[i] = s_old[i];
            m_run[i] = 0;
            if (s_old[i]) begin m_rel[i] = 1'b1; rel_now = 1'b1; end
            else m_press[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
        if (rel_now || st_old[i]) begin
          m_age[i] = 0;
        end else begin
          m_age[i]++;
          if (LP_EN && m_age[i] == LG) m_long[i] = 1'b1;
          if (LP_EN && m_age[i] > LG && ((m_age[i] - LG) % RP) == 0) m_rep[i] = 1'b1;
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = key_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("key_state", key_state, m_state);
    check("press_flag", press_flag, m_press);
    check("release_flag", release_flag, m_rel);
    check("long_flag", long_flag, m_long);
    check("repeat_flag", repeat_flag, m_rep);
    check("press_and_release", press_flag & release_flag, 0);
  endtask

  initial begin
    logic [NK-1:0] seen;
    logic [63:0]   rep_mask;
    int long_at, rel_at, other, r0, r1, idx;

    // reset state
    rst = 1'b1; key_in = '1;
    repeat (3) tick();
    check("rst_state", key_state, 2'b11);
    check("rst_flags", {press_flag, release_flag, long_flag, repeat_flag}, 0);
    rst = 1'b0;
    repeat (3) tick();

    // clean press on channel 0: pulse at the sixth edge
    key_in = 2'b10;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) check("r029_early", press_flag, 0);
    end
    check("r029_press", press_flag, 2'b01);
    check("r029_state", key_state, 2'b10);
    tick();
    check("r029_pulse_end", press_flag, 0);
    key_in = 2'b11;
    repeat (10) tick();

    // bounce every 2 cycles: nothing accepted
    seen = '0;
    for (int c = 0; c < 20; c++) begin
      key_in[0] = ((c / 2) % 2) == 1;
      tick();
      seen |= press_flag | release_flag;
    end
    key_in = 2'b11;
    repeat (8) begin
      tick();
      seen |= press_flag | release_flag;
    end
    check("r030_flags", seen, 0);
    check("r030_state", key_state, 2'b11);

    // long press and auto-repeat on channel 1
    key_in = 2'b01;
    for (int k = 0; k < 20 && !press_flag[1]; k++) tick();
    check("r031_press", press_flag, 2'b10);
    long_at = -1; rep_mask = '0; other = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (long_flag[1]) long_at = k;
      if (repeat_flag[1]) rep_mask[k] = 1'b1;
      other += int'(long_flag[0]) + int'(repeat_flag[0]);
    end
    check("r031_long_at", long_at, LP_EN ? 16 : -1);
    check("r031_repeats", rep_mask, LP_EN ? ((64'd1 << 24) | (64'd1 << 32) | (64'd1 << 40)) : 64'd0);
    check("r031_ch0_quiet", other, 0);
    key_in = 2'b11;
    rel_at = -1; other = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (release_flag[1] && rel_at < 0) rel_at = k;
      other += int'(long_flag[1]) + int'(repeat_flag[1]);
    end
    check("r031_release_at", rel_at, 6);
    check("r031_no_repeat_after", other, 0);

    // both keys pressed together, released 3 cycles apart
    key_in = 2'b00;
    repeat (6) tick();
    check("r032_press_both", press_flag, 2'b11);
    repeat (3) tick();
    key_in = 2'b10;
    r0 = -1; r1 = -1;
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) key_in = 2'b11;
      tick();
      if (release_flag[0] && r0 < 0) r0 = edge_no;
      if (release_flag[1] && r1 < 0) r1 = edge_no;
    end
    check("r032_gap", r0 - r1, 3);

    // reset mid-debounce, key still held
    key_in = 2'b10;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    check("r033_rst_state", key_state, 2'b11);
    check("r033_rst_flags", press_flag, 0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) check("r033_early", press_flag, 0);
    end
    check("r033_press", press_flag, 2'b01);
    key_in = 2'b11;
    repeat (10) tick();

    // randomized toggling and bouncing with occasional reset
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, NK - 1);
        key_in[idx] = ~key_in[idx];
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    key_in = '1;
    repeat (10) tick();
    check("final_state", key_state, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
